bit_serial_alu: RTL and testbench



---
 rtl/bit_serial_alu.sv | 168 ++++++++++++++++
 tb/tb_bit_serial_alu.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one bit-slice walked across the word, one bit per clock.
// Optional BIT_SERIAL_EARLY_EXIT_EN: SLT finishes as soon as the compare is decided.
module bit_serial_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       command,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] MSB_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {
    CMD_ADD  = 3'b000, CMD_SUB = 3'b001, CMD_XOR = 3'b010, CMD_SLT = 3'b011,
    CMD_AND  = 3'b100, CMD_NAND = 3'b101, CMD_NOR = 3'b110, CMD_OR = 3'b111
  } cmd_t;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, k_q, k_d, ans_q, ans_d;
  logic             carryout_q, carryout_d, overflow_q, overflow_d, zero_q, zero_d;

  logic abit, bbit, bbit_eff, sum, cout, rbit, last, arith;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    work_d     = work_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    k_d        = k_q;
    ans_d      = ans_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    rbit       = 1'b0;
    last       = 1'b0;

    abit     = a_q[cnt_q];
    bbit     = b_q[cnt_q];
    arith    = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);
    bbit_eff = (cmd_q == CMD_SUB) ? ~bbit : bbit;
    sum      = abit ^ bbit_eff ^ carry_q;
    cout     = (abit & bbit_eff) | (abit & carry_q) | (bbit_eff & carry_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cmd_d   = cmd_t'(command);
          a_d     = a;
          b_d     = b;
          work_d  = '0;
          cnt_d   = (cmd_t'(command) == CMD_SLT) ? MSB_IDX : '0;
          carry_d = (cmd_t'(command) == CMD_SUB);
          k_d     = 1'b1;
          ans_d   = 1'b0;
        end
      end
      S_RUN: begin
        unique case (cmd_q)
          CMD_ADD, CMD_SUB: begin
            rbit    = sum;
            carry_d = cout;
          end
          CMD_XOR:  rbit = abit ^ bbit;
          CMD_AND:  rbit = abit & bbit;
          CMD_NAND: rbit = ~(abit & bbit);
          CMD_NOR:  rbit = ~(abit | bbit);
          CMD_OR:   rbit = abit | bbit;
          CMD_SLT: begin
            // MSB decides by sign (a negative => less); lower bits by magnitude
            if (k_q && (abit != bbit)) begin
              k_d   = 1'b0;
              ans_d = (cnt_q == MSB_IDX) ? abit : bbit;
            end
          end
          default: rbit = 1'b0;
        endcase

        if (cmd_q == CMD_SLT) begin
`ifdef BIT_SERIAL_EARLY_EXIT_EN
          last = (cnt_q == '0) || !k_d;
`else
          last = (cnt_q == '0);
`endif
          if (!last) cnt_d = cnt_q - 1'b1;
        end else begin
          work_d[cnt_q] = rbit;
          last          = (cnt_q == MSB_IDX);
          if (!last) cnt_d = cnt_q + 1'b1;
        end

        if (last) begin
          state_d = S_DONE;
          if (cmd_q == CMD_SLT) begin
            result_d    = '0;
            result_d[0] = ans_d;
          end else begin
            result_d = work_d;
          end
          carryout_d = arith & cout;
          overflow_d = arith & (carry_q ^ cout);
          zero_d     = (result_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_ADD;
      a_q        <= '0;
      b_q        <= '0;
      work_q     <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      k_q        <= 1'b0;
      ans_q      <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      work_q     <= work_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      k_q        <= k_d;
      ans_q      <= ans_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed-vector bench for bit_serial_alu (WIDTH=32), hand-computed expectations.
module tb_bit_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  command = 3'b000;
  logic        busy, done, carryout, overflow, zero;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  bit_serial_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .command(command),
    .busy(busy), .done(done), .result(result), .carryout(carryout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] cmd, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_r, input logic exp_c,
                        input logic exp_v, input logic exp_z, input int lat_early);
    int          edges;
    int          exp_lat;
    bit          seen;
    bit          stable;
    logic [31:0] r0;
`ifdef BIT_SERIAL_EARLY_EXIT_EN
    exp_lat = lat_early;
`else
    exp_lat = 32;
`endif
    @(negedge clk);
    a = av; b = bv; command = cmd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r0 = result;
    stable = 1'b1;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
      else if (busy && result !== r0) stable = 1'b0;
    end
    check({tag, " latency"}, 32'(edges), 32'(exp_lat));
    check({tag, " result"}, result, exp_r);
    check({tag, " carryout"}, 32'(carryout), 32'(exp_c));
    check({tag, " overflow"}, 32'(overflow), 32'(exp_v));
    check({tag, " zero"}, 32'(zero), 32'(exp_z));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check({tag, " stable_while_busy"}, 32'(stable), 32'd1);
    @(posedge clk); #1;
    check({tag, " done_falls"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  first_done;
    int  second_done;
    int  glitch;
    bit  prev_done;
    bit  saw_done;

    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    check("rst carryout", 32'(carryout), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_wrap", 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 32);
    run_op("add_ovf",  3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 32);

    // Abandon an ADD partway through; outputs must clear immediately.
    @(negedge clk);
    a = 32'd1; b = 32'd2; command = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst carryout", 32'(carryout), 32'd0);
    check("midrst overflow", 32'(overflow), 32'd0);
    check("midrst zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst no_activity", 32'(saw_done), 32'd0);
    run_op("add_after_rst", 3'b000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32);

    run_op("sub_neg",  3'b001, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32);
    run_op("sub_eq",   3'b001, 32'd7, 32'd7, 32'h00000000, 1'b1, 1'b0, 1'b1, 32);

    run_op("xor",  3'b010, 32'hF0F0A5A5, 32'h0FF0FF00, 32'hFF005AA5, 1'b0, 1'b0, 1'b0, 32);
    run_op("and",  3'b100, 32'hF0F0A5A5, 32'h0FF0FF00, 32'h00F0A500, 1'b0, 1'b0, 1'b0, 32);
    run_op("nand", 3'b101, 32'hF0F0A5A5, 32'h0FF0FF00, 32'hFF0F5AFF, 1'b0, 1'b0, 1'b0, 32);
    run_op("nor",  3'b110, 32'hF0F0A5A5, 32'h0FF0FF00, 32'h000F005A, 1'b0, 1'b0, 1'b0, 32);
    run_op("or",   3'b111, 32'hF0F0A5A5, 32'h0FF0FF00, 32'hFFF0FFA5, 1'b0, 1'b0, 1'b0, 32);
    run_op("and_zero", 3'b100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b0, 1'b1, 32);

    run_op("slt_neg_pos", 3'b011, 32'h80000000, 32'h00000001, 32'd1, 1'b0, 1'b0, 1'b0, 1);
    run_op("slt_pos_neg", 3'b011, 32'h00000001, 32'h80000000, 32'd0, 1'b0, 1'b0, 1'b1, 1);
    run_op("slt_equal",   3'b011, 32'h12345678, 32'h12345678, 32'd0, 1'b0, 1'b0, 1'b1, 32);
    run_op("slt_lsb",     3'b011, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32);

    // start held high: ops repeat every WIDTH+2 cycles with single-cycle done.
    @(negedge clk);
    a = 32'd3; b = 32'd4; command = 3'b000; start = 1'b1;
    first_done = -1;
    second_done = -1;
    glitch = 0;
    prev_done = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (prev_done) glitch++;
        else if (first_done < 0) first_done = cyc;
        else if (second_done < 0) second_done = cyc;
        check("hold result", result, 32'd7);
      end
      prev_done = done;
    end
    start = 1'b0;
    check("hold period", 32'(second_done - first_done), 32'd34);
    check("hold done_width", 32'(glitch), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
